// File: rtl/mips_dmem_pkg.sv
// Shared definitions for the MIPS data-side memory port.
// Holds the peripheral address map, TXSTAT bit positions, the default
// RAM size and the address decode helper used by the top level.
package mips_dmem_pkg;

  localparam int RAM_AW_DEFAULT = 10;

  localparam logic [31:0] ADDR_CYCLE  = 32'hFFFF_FF00;
  localparam logic [31:0] ADDR_TXDATA = 32'hFFFF_FF04;
  localparam logic [31:0] ADDR_TXSTAT = 32'hFFFF_FF08;
  localparam logic [31:0] ADDR_LED    = 32'hFFFF_FF0C;

  localparam int STAT_EMPTY   = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_OVF     = 2;
  localparam int STAT_CNT_LSB = 4;

  typedef enum logic [2:0] {
    REGION_NONE,
    REGION_RAM,
    REGION_CYCLE,
    REGION_TXDATA,
    REGION_TXSTAT,
    REGION_LED
  } region_e;

  // Byte-lane bits are ignored; anything outside RAM and the four
  // peripheral words decodes to REGION_NONE.
  function automatic region_e decode(logic [31:0] a, int ram_aw);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if ((a >> (ram_aw + 2)) == 32'd0) return REGION_RAM;
    case (w)
      ADDR_CYCLE:  return REGION_CYCLE;
      ADDR_TXDATA: return REGION_TXDATA;
      ADDR_TXSTAT: return REGION_TXSTAT;
      ADDR_LED:    return REGION_LED;
      default:     return REGION_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mips_tx_fifo.sv
// Byte transmit FIFO for the data memory port.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   push, din     write request and byte
//   pop           consumer takes the head this cycle (ignored when empty)
//   dout          head byte, 0 while empty
//   empty, full   occupancy flags
//   count         number of stored bytes
//   push_ok       a push this cycle would be accepted (!full | pop)
module mips_tx_fifo
  import mips_dmem_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int PW = $clog2(FIFO_DEPTH),
  parameter int CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [7:0]    din,
  input  logic          pop,
  output logic [7:0]    dout,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count,
  output logic          push_ok
);

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(FIFO_DEPTH));
  assign do_pop  = pop & ~empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_ok = ~full | do_pop;
  assign do_push = push & push_ok;
  assign dout    = empty ? 8'h00 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mips_dmem_port.sv
// Data-side memory responder for the pipelined MIPS core.
// Serves word RAM plus memory-mapped cycle counter, transmit FIFO,
// FIFO status and LED register. Reads are combinational from addr.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   addr, wdata         byte address and store data from the core
//   memwrite            one-cycle store strobe
//   rdata               read data for addr (pre-edge state)
//   tx_data, tx_valid   FIFO head byte and not-empty
//   tx_ready            consumer accepts the head
//   led                 LED register
module mips_dmem_port
  import mips_dmem_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int RAM_AW     = RAM_AW_DEFAULT,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              memwrite,
  output logic [DATA_W-1:0] rdata,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [7:0]        led
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  region_e           region;
  logic [DATA_W-1:0] ram [2**RAM_AW];
  logic [DATA_W-1:0] cycle_cnt;
  logic              overflow;
  logic              fifo_empty;
  logic              fifo_full;
  logic [CW-1:0]     fifo_count;
  logic              fifo_push_ok;
  logic              tx_push;
  logic              tx_pop;
  logic [3:0]        cnt4;
  logic [7:0]        stat;

  assign region  = decode(addr, RAM_AW);
  assign tx_push = memwrite & (region == REGION_TXDATA);
  assign tx_pop  = tx_valid & tx_ready;

  mips_tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (tx_push),
    .din     (wdata[7:0]),
    .pop     (tx_pop),
    .dout    (tx_data),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count),
    .push_ok (fifo_push_ok)
  );

  assign tx_valid = ~fifo_empty;

  always_ff @(posedge clk) begin
    if (memwrite && region == REGION_RAM) ram[addr[RAM_AW+1:2]] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt <= '0;
      led       <= '0;
      overflow  <= 1'b0;
    end else begin
      if (memwrite && region == REGION_CYCLE) cycle_cnt <= wdata;
      else                                    cycle_cnt <= cycle_cnt + DATA_W'(1);
      if (memwrite && region == REGION_LED) led <= wdata[7:0];
      // Set takes priority over the clear from a TXSTAT write.
      if (tx_push && !fifo_push_ok)                    overflow <= 1'b1;
      else if (memwrite && region == REGION_TXSTAT)    overflow <= 1'b0;
    end
  end

  always_comb begin
    cnt4 = 4'(fifo_count);
    stat = '0;
    stat[STAT_CNT_LSB +: 4] = cnt4;
    stat[STAT_OVF]          = overflow;
    stat[STAT_FULL]         = fifo_full;
    stat[STAT_EMPTY]        = fifo_empty;
  end

  always_comb begin
    rdata = '0;
    case (region)
      REGION_RAM:    rdata = ram[addr[RAM_AW+1:2]];
      REGION_CYCLE:  rdata = cycle_cnt;
      REGION_TXSTAT: rdata = DATA_W'(stat);
      REGION_LED:    rdata = DATA_W'(led);
      default:       rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_mips_dmem_port.sv
// Directed self-checking bench for mips_dmem_port.
module tb_mips_dmem_port;

  localparam logic [31:0] A_CYCLE  = 32'hFFFF_FF00;
  localparam logic [31:0] A_TXDATA = 32'hFFFF_FF04;
  localparam logic [31:0] A_TXSTAT = 32'hFFFF_FF08;
  localparam logic [31:0] A_LED    = 32'hFFFF_FF0C;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        memwrite;
  logic [31:0] rdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  led;

  int checks = 0;
  int errors = 0;

  mips_dmem_port dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .wdata    (wdata),
    .memwrite (memwrite),
    .rdata    (rdata),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .led      (led)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; memwrite = 1'b1;
    tick();
    memwrite = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(tag, rdata, exp);
  endtask

  logic [7:0] drain_q [$];

  initial begin
    rst = 1'b1; addr = '0; wdata = '0; memwrite = 1'b0; tx_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_led", 32'(led), 32'd0);
    rd("rst_txstat", A_TXSTAT, 32'h01);
    rd("rst_cycle", A_CYCLE, 32'd0);

    repeat (5) tick();
    rd("cycle_5", A_CYCLE, 32'd5);
    store(A_CYCLE, 32'hFFFF_FFFE);
    rd("cycle_load", A_CYCLE, 32'hFFFF_FFFE);
    tick(); tick();
    rd("cycle_wrap", A_CYCLE, 32'd0);

    store(32'h10, 32'hDEAD_BEEF);
    rd("ram_10", 32'h10, 32'hDEAD_BEEF);
    rd("ram_13", 32'h13, 32'hDEAD_BEEF);
    rd("unmapped_8000", 32'h8000_0000, 32'd0);
    rd("unmapped_ff10", 32'hFFFF_FF10, 32'd0);
    store(32'h8000_0000, 32'h1234_5678);
    rd("unmapped_wr", 32'h8000_0000, 32'd0);

    store(A_LED, 32'h1234_56A5);
    chk("led_out", 32'(led), 32'hA5);
    rd("led_read", A_LED, 32'hA5);

    for (int i = 0; i < 8; i++) begin
      store(A_TXDATA, 32'h41 + 32'(i));
      if (i == 0) begin
        chk("first_valid", 32'(tx_valid), 32'd1);
        chk("first_data", 32'(tx_data), 32'h41);
      end
    end
    rd("txdata_read", A_TXDATA, 32'd0);
    rd("stat_full", A_TXSTAT, 32'h82);
    store(A_TXDATA, 32'h49);
    rd("stat_ovf", A_TXSTAT, 32'h86);
    store(A_TXSTAT, 32'h0);
    rd("stat_clr", A_TXSTAT, 32'h82);

    tx_ready = 1'b1;
    store(A_TXDATA, 32'h50);
    tx_ready = 1'b0;
    chk("pp_head", 32'(tx_data), 32'h42);
    rd("pp_stat", A_TXSTAT, 32'h82);

    drain_q = '{8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h50};
    tx_ready = 1'b1;
    foreach (drain_q[i]) begin
      chk("drain_valid", 32'(tx_valid), 32'd1);
      chk("drain_data", 32'(tx_data), 32'(drain_q[i]));
      tick();
    end
    tx_ready = 1'b0;
    chk("drained_valid", 32'(tx_valid), 32'd0);
    rd("drained_stat", A_TXSTAT, 32'h01);

    tx_ready = 1'b1;
    store(A_TXDATA, 32'h77);
    tx_ready = 1'b0;
    rd("empty_pp_stat", A_TXSTAT, 32'h10);
    chk("empty_pp_data", 32'(tx_data), 32'h77);
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    chk("empty_pp_drain", 32'(tx_valid), 32'd0);

    store(A_LED, 32'hA5);
    store(A_TXDATA, 32'h61);
    store(A_TXDATA, 32'h62);
    store(A_TXDATA, 32'h63);
    rd("three_stat", A_TXSTAT, 32'h30);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", 32'(tx_valid), 32'd0);
    chk("mid_rst_led", 32'(led), 32'd0);
    rd("mid_rst_stat", A_TXSTAT, 32'h01);
    rd("mid_rst_cycle", A_CYCLE, 32'd0);
    rd("mid_rst_ram", 32'h10, 32'hDEAD_BEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
